// File: rtl/isp_ccm_pkg.sv
// Shared constants for the colour-correction-matrix stage: coefficient
// addresses, the identity matrix, datapath width helpers and the commit states.
package isp_ccm_pkg;

  localparam int DEF_BITS      = 8;
  localparam int DEF_COEF_BITS = 12;
  localparam int DEF_FRAC      = 8;

  localparam int CCM_ONE  = 256;
  localparam int NUM_COEF = 9;

  localparam logic [3:0] ADDR_C00 = 4'd0;
  localparam logic [3:0] ADDR_C01 = 4'd1;
  localparam logic [3:0] ADDR_C02 = 4'd2;
  localparam logic [3:0] ADDR_C10 = 4'd3;
  localparam logic [3:0] ADDR_C11 = 4'd4;
  localparam logic [3:0] ADDR_C12 = 4'd5;
  localparam logic [3:0] ADDR_C20 = 4'd6;
  localparam logic [3:0] ADDR_C21 = 4'd7;
  localparam logic [3:0] ADDR_C22 = 4'd8;

  // Row-major identity, expressed in units where CCM_ONE means 1.0.
  localparam int IDENTITY [NUM_COEF] = '{CCM_ONE, 0, 0, 0, CCM_ONE, 0, 0, 0, CCM_ONE};

  // Zero-extended pixel (bits+1, signed) times a signed coefficient.
  function automatic int prod_width(input int bits, input int coef_bits);
    return bits + 1 + coef_bits;
  endfunction

  // Two guard bits absorb the three-term row sum plus the rounding constant.
  function automatic int sum_width(input int bits, input int coef_bits);
    return prod_width(bits, coef_bits) + 2;
  endfunction

  localparam int PROD_W = prod_width(DEF_BITS, DEF_COEF_BITS);
  localparam int SUM_W  = sum_width(DEF_BITS, DEF_COEF_BITS);

  typedef enum logic {
    ST_IDLE,
    ST_PENDING
  } commit_state_t;

endpackage

// File: rtl/isp_ccm_row.sv
// One output row of the colour matrix: three products, rounded sum, clamp.
// Three registered stages; the result lands on y three edges after sampling.
module isp_ccm_row
  import isp_ccm_pkg::*;
#(
  parameter int BITS      = DEF_BITS,
  parameter int COEF_BITS = DEF_COEF_BITS,
  parameter int FRAC      = DEF_FRAC,
  parameter int PW        = PROD_W,
  parameter int SW        = SUM_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic        [BITS-1:0]      r,
  input  logic        [BITS-1:0]      g,
  input  logic        [BITS-1:0]      b,
  input  logic signed [COEF_BITS-1:0] c0,
  input  logic signed [COEF_BITS-1:0] c1,
  input  logic signed [COEF_BITS-1:0] c2,
  output logic        [BITS-1:0]      y
);

  localparam int RND = 2 ** (FRAC - 1);

  logic signed [BITS:0]      x     [3];
  logic signed [COEF_BITS-1:0] c   [3];
  logic signed [PW-1:0]      prod_reg [3];
  logic signed [SW-1:0]      acc;
  logic signed [SW-1:0]      sum_reg;
  logic                      sat_hi;

  assign x[0] = {1'b0, r};
  assign x[1] = {1'b0, g};
  assign x[2] = {1'b0, b};
  assign c[0] = c0;
  assign c[1] = c1;
  assign c[2] = c2;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_mul
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          prod_reg[gi] <= '0;
        end else begin
          prod_reg[gi] <= PW'(x[gi]) * PW'(c[gi]);
        end
      end
    end
  endgenerate

  always_comb begin
    acc = SW'(prod_reg[0]) + SW'(prod_reg[1]) + SW'(prod_reg[2]) + SW'(RND);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_reg <= '0;
    end else begin
      sum_reg <= acc >>> FRAC;
    end
  end

  // Non-negative values with any bit set above BITS exceed the output range.
  assign sat_hi = |sum_reg[SW-2:BITS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y <= '0;
    end else if (sum_reg[SW-1]) begin
      y <= '0;
    end else if (sat_hi) begin
      y <= {BITS{1'b1}};
    end else begin
      y <= sum_reg[BITS-1:0];
    end
  end

endmodule

// File: rtl/isp_ccm.sv
// 3x3 colour-correction stage: shadow/active coefficient banks with
// frame-aligned commit, three matrix rows, timing delay line and bypass.
module isp_ccm
  import isp_ccm_pkg::*;
#(
  parameter int BITS      = DEF_BITS,
  parameter int COEF_BITS = DEF_COEF_BITS,
  parameter int FRAC      = DEF_FRAC
) (
  input  logic                 pclk,
  input  logic                 rst,
  input  logic                 in_href,
  input  logic                 in_vsync,
  input  logic                 in_de,
  input  logic [BITS-1:0]      in_r,
  input  logic [BITS-1:0]      in_g,
  input  logic [BITS-1:0]      in_b,
  input  logic                 bypass,
  input  logic                 cfg_we,
  input  logic [3:0]           cfg_addr,
  input  logic [COEF_BITS-1:0] cfg_data,
  input  logic                 cfg_commit,
  output logic                 cfg_pending,
  output logic                 out_href,
  output logic                 out_vsync,
  output logic                 out_de,
  output logic [BITS-1:0]      out_r,
  output logic [BITS-1:0]      out_g,
  output logic [BITS-1:0]      out_b
);

  localparam int ROW_PW = prod_width(BITS, COEF_BITS);
  localparam int ROW_SW = sum_width(BITS, COEF_BITS);

  logic signed [COEF_BITS-1:0] shadow_reg [NUM_COEF];
  logic signed [COEF_BITS-1:0] active_reg [NUM_COEF];
  commit_state_t               state_reg;
  logic                        vsync_prev_reg;
  logic                        boundary;
  logic                        load;

  logic [2:0]      href_pipe;
  logic [2:0]      vsync_pipe;
  logic [2:0]      de_pipe;
  logic [2:0]      bypass_pipe;
  logic [BITS-1:0] r_pipe [3];
  logic [BITS-1:0] g_pipe [3];
  logic [BITS-1:0] b_pipe [3];
  logic [BITS-1:0] row_y  [3];

  function automatic logic signed [COEF_BITS-1:0] ident_coef(input int idx);
    return COEF_BITS'((IDENTITY[idx] * (2 ** FRAC)) / CCM_ONE);
  endfunction

  assign boundary = in_vsync & ~vsync_prev_reg;
  // A commit arriving on the boundary cycle itself transfers immediately.
  assign load     = boundary & (cfg_commit | (state_reg == ST_PENDING));

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      vsync_prev_reg <= 1'b0;
    end else begin
      vsync_prev_reg <= in_vsync;
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      cfg_pending <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (cfg_commit && !boundary) begin
            state_reg   <= ST_PENDING;
            cfg_pending <= 1'b1;
          end
        end
        ST_PENDING: begin
          if (boundary) begin
            state_reg   <= ST_IDLE;
            cfg_pending <= 1'b0;
          end
        end
        default: begin
          state_reg   <= ST_IDLE;
          cfg_pending <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_COEF; i++) begin
        shadow_reg[i] <= ident_coef(i);
      end
    end else if (cfg_we) begin
      case (cfg_addr)
        ADDR_C00: shadow_reg[0] <= cfg_data;
        ADDR_C01: shadow_reg[1] <= cfg_data;
        ADDR_C02: shadow_reg[2] <= cfg_data;
        ADDR_C10: shadow_reg[3] <= cfg_data;
        ADDR_C11: shadow_reg[4] <= cfg_data;
        ADDR_C12: shadow_reg[5] <= cfg_data;
        ADDR_C20: shadow_reg[6] <= cfg_data;
        ADDR_C21: shadow_reg[7] <= cfg_data;
        ADDR_C22: shadow_reg[8] <= cfg_data;
        default: ;
      endcase
    end
  end

  // Non-blocking copy picks up the shadow as it stood before this edge.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_COEF; i++) begin
        active_reg[i] <= ident_coef(i);
      end
    end else if (load) begin
      for (int i = 0; i < NUM_COEF; i++) begin
        active_reg[i] <= shadow_reg[i];
      end
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      href_pipe   <= '0;
      vsync_pipe  <= '0;
      de_pipe     <= '0;
      bypass_pipe <= '0;
      for (int i = 0; i < 3; i++) begin
        r_pipe[i] <= '0;
        g_pipe[i] <= '0;
        b_pipe[i] <= '0;
      end
    end else begin
      href_pipe   <= {href_pipe[1:0], in_href};
      vsync_pipe  <= {vsync_pipe[1:0], in_vsync};
      de_pipe     <= {de_pipe[1:0], in_de};
      bypass_pipe <= {bypass_pipe[1:0], bypass};
      r_pipe[0]   <= in_r;
      g_pipe[0]   <= in_g;
      b_pipe[0]   <= in_b;
      for (int i = 1; i < 3; i++) begin
        r_pipe[i] <= r_pipe[i-1];
        g_pipe[i] <= g_pipe[i-1];
        b_pipe[i] <= b_pipe[i-1];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_row
      isp_ccm_row #(
        .BITS      (BITS),
        .COEF_BITS (COEF_BITS),
        .FRAC      (FRAC),
        .PW        (ROW_PW),
        .SW        (ROW_SW)
      ) u_row (
        .clk (pclk),
        .rst (rst),
        .r   (in_r),
        .g   (in_g),
        .b   (in_b),
        .c0  (active_reg[3*gi]),
        .c1  (active_reg[3*gi+1]),
        .c2  (active_reg[3*gi+2]),
        .y   (row_y[gi])
      );
    end
  endgenerate

  // Bypass flag travels with its pixel, so the select is already aligned.
  assign out_r     = bypass_pipe[2] ? r_pipe[2] : row_y[0];
  assign out_g     = bypass_pipe[2] ? g_pipe[2] : row_y[1];
  assign out_b     = bypass_pipe[2] ? b_pipe[2] : row_y[2];
  assign out_href  = href_pipe[2];
  assign out_vsync = vsync_pipe[2];
  assign out_de    = de_pipe[2];

endmodule

// File: tb/tb_isp_ccm.sv
// Scoreboard bench for isp_ccm: a driver pushes model expectations into a
// queue, a monitor on the falling edge pops and compares them.
module tb_isp_ccm;

  localparam int ONE = 256;

  logic        pclk;
  logic        rst;
  logic        in_href, in_vsync, in_de;
  logic [7:0]  in_r, in_g, in_b;
  logic        bypass;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [11:0] cfg_data;
  logic        cfg_commit;
  logic        cfg_pending;
  logic        out_href, out_vsync, out_de;
  logic [7:0]  out_r, out_g, out_b;

  isp_ccm dut (
    .pclk        (pclk),
    .rst         (rst),
    .in_href     (in_href),
    .in_vsync    (in_vsync),
    .in_de       (in_de),
    .in_r        (in_r),
    .in_g        (in_g),
    .in_b        (in_b),
    .bypass      (bypass),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .cfg_commit  (cfg_commit),
    .cfg_pending (cfg_pending),
    .out_href    (out_href),
    .out_vsync   (out_vsync),
    .out_de      (out_de),
    .out_r       (out_r),
    .out_g       (out_g),
    .out_b       (out_b)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int edges = 0;
  always @(posedge pclk) edges <= edges + 1;

  typedef struct {
    int due;
    bit href;
    bit vsync;
    bit de;
    int r;
    int g;
    int b;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  int m_shadow [9];
  int m_active [9];
  bit m_pending;
  bit m_vprev;

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Floor((c.x + 0.5) in units of 1/256), then clamped to 0..255.
  function automatic int ccm_row(input int c0, input int c1, input int c2,
                                 input int r, input int g, input int b);
    int s;
    int v;
    s = c0 * r + c1 * g + c2 * b + ONE / 2;
    if (s >= 0) v = s / ONE;
    else        v = -((-s + ONE - 1) / ONE);
    if (v < 0)   return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 9; i++) begin
      m_shadow[i] = (i % 4 == 0) ? ONE : 0;
      m_active[i] = m_shadow[i];
    end
    m_pending = 1'b0;
    m_vprev   = 1'b0;
  endtask

  // One pixel clock: queue the expected output, clock, advance the model.
  task automatic step(input bit fixed = 1'b0, input int fr = 0, input int fg = 0, input int fb = 0);
    exp_t e;
    bit   boundary;
    bit   load;
    e.due   = edges + 3;
    e.href  = in_href;
    e.vsync = in_vsync;
    e.de    = in_de;
    if (fixed) begin
      e.r = fr; e.g = fg; e.b = fb;
    end else if (bypass) begin
      e.r = in_r; e.g = in_g; e.b = in_b;
    end else begin
      e.r = ccm_row(m_active[0], m_active[1], m_active[2], in_r, in_g, in_b);
      e.g = ccm_row(m_active[3], m_active[4], m_active[5], in_r, in_g, in_b);
      e.b = ccm_row(m_active[6], m_active[7], m_active[8], in_r, in_g, in_b);
    end
    q.push_back(e);
    @(posedge pclk);
    boundary = in_vsync && !m_vprev;
    load = boundary && (cfg_commit || m_pending);
    if (load) m_active = m_shadow;
    m_pending = load ? 1'b0 : (m_pending || cfg_commit);
    if (cfg_we && int'(cfg_addr) <= 8) m_shadow[cfg_addr] = int'($signed(cfg_data));
    m_vprev = in_vsync;
    #1;
    chk("cfg_pending", cfg_pending, m_pending);
    cfg_we     = 1'b0;
    cfg_commit = 1'b0;
  endtask

  task automatic wr(input int addr, input int val);
    cfg_we   = 1'b1;
    cfg_addr = 4'(addr);
    cfg_data = 12'(val);
    step();
  endtask

  task automatic vsync_pulse();
    in_vsync = 1'b1;
    step();
    in_vsync = 1'b0;
    step();
  endtask

  task automatic pix(input int r, input int g, input int b);
    in_href = 1'b1;
    in_de   = 1'b1;
    in_r    = 8'(r);
    in_g    = 8'(g);
    in_b    = 8'(b);
  endtask

  // Monitor: every cycle is an output cycle; compare the entry due now.
  initial begin
    exp_t e;
    forever begin
      @(negedge pclk);
      if (!rst) begin
        while (q.size() > 0 && q[0].due < edges) begin
          e = q.pop_front();
          total++;
          bad++;
          $display("FAIL missed_output: due edge %0d, now edge %0d", e.due, edges);
        end
        if (q.size() > 0 && q[0].due == edges) begin
          e = q.pop_front();
          $display("pix edge=%0d out=(%0d,%0d,%0d) hvd=%0d%0d%0d exp=(%0d,%0d,%0d) hvd=%0d%0d%0d",
                   edges, out_r, out_g, out_b, out_href, out_vsync, out_de,
                   e.r, e.g, e.b, e.href, e.vsync, e.de);
          chk("out_href", out_href, e.href);
          chk("out_vsync", out_vsync, e.vsync);
          chk("out_de", out_de, e.de);
          chk("out_r", out_r, e.r);
          chk("out_g", out_g, e.g);
          chk("out_b", out_b, e.b);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, total=%0d", total);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    in_href = 0; in_vsync = 0; in_de = 0;
    in_r = 0; in_g = 0; in_b = 0;
    bypass = 0; cfg_we = 0; cfg_addr = 0; cfg_data = 0; cfg_commit = 0;
    model_reset();
    repeat (3) @(posedge pclk);
    #1;
    chk("reset_out_r", out_r, 0);
    chk("reset_out_g", out_g, 0);
    chk("reset_out_b", out_b, 0);
    chk("reset_timing", {out_href, out_vsync, out_de}, 0);
    chk("reset_pending", cfg_pending, 0);
    @(negedge pclk) rst = 1'b0;
    @(posedge pclk);
    #1;

    // Identity after reset.
    pix(100, 150, 200);
    step(1'b1, 100, 150, 200);
    in_href = 0; in_de = 0;
    step();

    // Saturation: row0 = (512,0,0), row1 = (0,-256,0).
    wr(0, 512);
    wr(4, -256);
    cfg_commit = 1'b1;
    step();
    chk("pending_after_commit", cfg_pending, 1);
    vsync_pulse();
    chk("pending_after_boundary", cfg_pending, 0);
    pix(200, 50, 7);
    step(1'b1, 255, 0, 7);

    // Rounding: row0 = (128,0,0).
    wr(0, 128);
    cfg_commit = 1'b1;
    step();
    vsync_pulse();
    pix(3, 0, 0);
    step(1'b1, 2, 0, 0);
    pix(1, 0, 0);
    step(1'b1, 1, 0, 0);

    // Deferred commit mid-frame.
    cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 12'd0; cfg_commit = 1'b1;
    pix(3, 0, 0);
    step(1'b1, 2, 0, 0);
    chk("deferred_pending", cfg_pending, 1);
    step(1'b1, 2, 0, 0);
    vsync_pulse();
    chk("deferred_cleared", cfg_pending, 0);
    pix(3, 0, 0);
    step(1'b1, 0, 0, 0);

    // Commit on the boundary cycle: transfer now, pending never set.
    wr(0, 256);
    cfg_commit = 1'b1;
    in_vsync = 1'b1;
    step();
    chk("commit_on_boundary", cfg_pending, 0);
    in_vsync = 1'b0;
    pix(3, 0, 0);
    step(1'b1, 3, 0, 0);

    // Write on the boundary cycle: old shadow goes active, new stays shadow.
    wr(0, 128);
    cfg_commit = 1'b1;
    step();
    cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 12'd512;
    vsync_pulse();
    pix(3, 0, 0);
    step(1'b1, 2, 0, 0);
    cfg_commit = 1'b1;
    step(1'b1, 2, 0, 0);
    vsync_pulse();
    pix(3, 0, 0);
    step(1'b1, 6, 0, 0);

    // Out-of-range address ignored.
    wr(12, 0);
    cfg_commit = 1'b1;
    step();
    vsync_pulse();
    pix(100, 50, 9);
    step(1'b1, 200, 0, 9);

    // Bypass with a non-identity matrix, toggled on a pixel boundary.
    bypass = 1'b1;
    pix(200, 50, 9);
    step(1'b1, 200, 50, 9);
    bypass = 1'b0;
    pix(100, 50, 9);
    step(1'b1, 200, 0, 9);

    // Randomised traffic.
    for (int n = 0; n < 1500; n++) begin
      in_href = 1'($urandom_range(0, 1));
      in_de   = in_href & 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) in_vsync = ~in_vsync;
      in_r = 8'($urandom_range(0, 255));
      in_g = 8'($urandom_range(0, 255));
      in_b = 8'($urandom_range(0, 255));
      bypass = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) begin
        cfg_we   = 1'b1;
        cfg_addr = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 1) == 0) cfg_data = 12'($urandom_range(0, 4095));
        else cfg_data = 12'(int'($urandom_range(0, 600)) - 300);
      end
      cfg_commit = ($urandom_range(0, 15) == 0);
      step();
    end

    // Reset mid-line: outputs clear at once, matrix back to identity.
    in_vsync = 1'b0;
    bypass = 1'b0;
    wr(0, 512);
    cfg_commit = 1'b1;
    step();
    pix(77, 88, 99);
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_out_r", out_r, 0);
    chk("async_rst_out_g", out_g, 0);
    chk("async_rst_out_b", out_b, 0);
    chk("async_rst_timing", {out_href, out_vsync, out_de}, 0);
    chk("async_rst_pending", cfg_pending, 0);
    q.delete();
    model_reset();
    in_href = 0; in_de = 0; in_r = 0; in_g = 0; in_b = 0;
    @(posedge pclk);
    @(negedge pclk) rst = 1'b0;
    @(posedge pclk);
    #1;
    vsync_pulse();
    pix(100, 150, 200);
    step(1'b1, 100, 150, 200);
    in_href = 0; in_de = 0; in_r = 0; in_g = 0; in_b = 0;

    repeat (5) @(posedge pclk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
